tc_psum_buffer: RTL and testbench
=================================

TC_PSUM_BUFFER -- requirements
Module: tc_psum_buffer

Interface
REQ-001 SHALL have parameter N_MERGE, default 16, the number of merge lanes per row.
REQ-002 SHALL have parameter DW_DATA, default 32, the lane width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, the number of psum row slots; AW = clog2(DEPTH).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, the number of result FIFO entries.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  merge-step issue request.
- in_ready  output  1  issue accepted when in_valid and in_ready are both 1.
- in_addr  input  AW  psum slot.
- in_first  input  1  first k-step; psum is taken as zero.
- in_last  input  1  final k-step; result goes to the FIFO.
- psum_out  output  N_MERGE*DW_DATA  psum driven to the merge tree's in_psum in the issue cycle.
- mt_result  input  N_MERGE*DW_DATA  merge tree output.
- out_valid  output  1  result FIFO not empty.
- out_ready  input  1  consumer accept.
- out_addr  output  AW  slot of the head result.
- out_data  output  N_MERGE*DW_DATA  head result.

Function
REQ-006 SHALL treat the merge tree latency as exactly 3 cycles: the psum presented with an issue at cycle t is summed into mt_result valid at cycle t+3.
REQ-007 SHALL keep a 3-stage in-flight pipeline (S1..S3) of {valid, addr, last}, advancing every cycle with no stall.
REQ-008 SHALL enter an accepted issue into S1 on the next edge; S3 is "retiring" when it holds the cycle-t+3 entry.
REQ-009 SHALL drive psum_out combinationally as follows: zero if in_first; else the retiring mt_result if S3 is valid, S3.addr == in_addr and S3 is not last (bypass); else buffer[in_addr].
REQ-010 SHALL deassert in_ready when in_valid, !in_first, and S1 or S2 holds a valid entry with addr == in_addr (RAW hazard stall).
REQ-011 SHALL also deassert in_ready when in_last is 1 and (fifo_count + in-flight last entries in S1..S3) >= FIFO_DEPTH (credit rule), so that the FIFO never overflows.
REQ-012 SHALL otherwise hold in_ready at 1, including when in_valid is 0.
REQ-013 SHALL, on a retiring non-last entry, write mt_result into buffer[S3.addr].
REQ-014 SHALL, on a retiring last entry, push {S3.addr, mt_result} into the FIFO and leave the buffer unchanged.
REQ-015 SHALL use wrap-around modular DW_DATA arithmetic with no saturation; the block itself performs no addition.
REQ-016 SHALL operate the FIFO in order, with out_valid = (count != 0) and a pop on out_valid && out_ready.
REQ-017 SHALL allow a simultaneous push and pop in the same cycle, leaving count unchanged, including when the FIFO is full.
REQ-018 SHALL keep out_data and out_addr stable while out_valid is 1 and out_ready is 0.
REQ-019 SHALL permit an in_first issue to the same slot as an in-flight entry without a stall; that older entry's retirement still writes the buffer.
REQ-020 SHALL ignore in_addr, in_first and in_last when in_valid is 0.

Reset
REQ-021 SHALL, while reset is asserted, immediately clear S1..S3 valid bits, the FIFO count and pointers, and every buffer slot to 0.
REQ-022 SHALL hold out_valid at 0 and in_ready at 1 during reset; psum_out SHALL be 0 whenever it comes from the cleared buffer.
REQ-023 SHALL discard in-flight entries on a reset asserted mid-operation, so that no buffer write or FIFO push occurs for them.

Verification
REQ-024 Single-lane chain: issue slot 0, first (mt_result 5 at t+3), then step 2 (mt_result 12), then step 3 last -> psum_out 0, then 5, then 12; FIFO receives {0, 12+...} per tree output; out_valid rises 4 cycles after the last issue.
REQ-025 Back-to-back same slot: first issue to slot 1 at t, non-first issue to slot 1 at t+1 -> in_ready 0 at t+1 and t+2; accepted at t+3 with psum_out = retiring mt_result (bypass).
REQ-026 Interleaved slots 0,1,2,3 round-robin with no first/last stalls -> in_ready constantly 1; each slot accumulates its own sequence correctly.
REQ-027 Credit: FIFO_DEPTH=4 and out_ready=0; issue 5 last steps to distinct slots -> the 5th stalls until out_ready pops 1; count never exceeds 4.
REQ-028 Full FIFO plus retiring last entry with out_ready=1 in the same cycle -> push and pop together; count stays 4; order preserved.
REQ-029 Reset asserted with 3 entries in flight -> no FIFO push, buffer reads 0, out_valid 0 on the first cycle after release.

Source files
------------

// File: rtl/tc_psum_buffer.sv
// Partial-sum row buffer for the merge tree: 3-stage in-flight tracking,
// retire-bypass, RAW stall, credit-guarded result FIFO.
module tc_psum_buffer #(
  parameter int N_MERGE    = 16,
  parameter int DW_DATA    = 32,
  parameter int DEPTH      = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int W  = N_MERGE * DW_DATA
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic          in_first,
  input  logic          in_last,
  output logic [W-1:0]  psum_out,
  input  logic [W-1:0]  mt_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [W-1:0]  out_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 4);

  logic [2:0]    v_q, v_d;
  logic [2:0]    l_q, l_d;
  logic [AW-1:0] a_q [3];
  logic [AW-1:0] a_d [3];
  logic [W-1:0]  buf_q [DEPTH];
  logic [AW-1:0] fa_q [FIFO_DEPTH];
  logic [W-1:0]  fd_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          raw, no_credit, issue;
  logic          retire, bypass, push, pop;
  logic [CW-1:0] pend;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign retire = v_q[2];
  assign push   = retire & l_q[2];
  assign pop    = out_valid & out_ready;
  assign bypass = retire & ~l_q[2] & (a_q[2] == in_addr);

  // Lasts still in flight already own a FIFO slot.
  assign pend = cnt_q
              + CW'(v_q[0] & l_q[0])
              + CW'(v_q[1] & l_q[1])
              + CW'(v_q[2] & l_q[2]);

  assign raw = in_valid & ~in_first
             & ((v_q[0] & (a_q[0] == in_addr))
              | (v_q[1] & (a_q[1] == in_addr)));

  assign no_credit = in_valid & in_last
                   & (pend >= CW'(FIFO_DEPTH));

  assign in_ready = ~(raw | no_credit);
  assign issue    = in_valid & in_ready;

  always_comb begin
    psum_out = buf_q[in_addr];
    if (in_first)    psum_out = '0;
    else if (bypass) psum_out = mt_result;
  end

  always_comb begin
    v_d    = {v_q[1:0], issue};
    l_d    = {l_q[1:0], in_last};
    a_d[0] = in_addr;
    a_d[1] = a_q[0];
    a_d[2] = a_q[1];
    wp_d   = push ? nxt(wp_q) : wp_q;
    rp_d   = pop ? nxt(rp_q) : rp_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= '0;
      l_q   <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < 3; i++) a_q[i] <= '0;
    end else begin
      v_q   <= v_d;
      l_q   <= l_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < 3; i++) a_q[i] <= a_d[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (retire && !l_q[2]) begin
      buf_q[a_q[2]] <= mt_result;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wp_q] <= a_q[2];
      fd_q[wp_q] <= mt_result;
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_addr  = fa_q[rp_q];
  assign out_data  = fd_q[rp_q];

endmodule

// File: tb/tb_tc_psum_buffer.sv
// Randomized bench for tc_psum_buffer: per-slot accumulator model,
// bench-side merge tree, result scoreboard popped by a monitor.
module tb_tc_psum_buffer;

  localparam int NM    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int FD    = 4;
  localparam int AW    = 2;
  localparam int W     = NM * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic          in_first = 1'b0;
  logic          in_last = 1'b0;
  logic [W-1:0]  psum_out;
  logic [W-1:0]  mt_result = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [W-1:0]  out_data;

  tc_psum_buffer #(
    .N_MERGE(NM), .DW_DATA(DW), .DEPTH(DEPTH), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_first(in_first), .in_last(in_last),
    .psum_out(psum_out), .mt_result(mt_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    int            c;
  } res_t;

  res_t          exp_q[$];
  logic [W-1:0]  sched[int];
  logic [W-1:0]  acc[DEPTH];
  int            hc[4];
  logic [AW-1:0] ha[4];
  int            cyc = 10;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] vadd(input logic [W-1:0] x, y);
    logic [W-1:0] r;
    for (int i = 0; i < NM; i++) r[i*DW +: DW] = x[i*DW +: DW] + y[i*DW +: DW];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    sched.delete();
    for (int i = 0; i < DEPTH; i++) acc[i] = '0;
    for (int i = 0; i < 4; i++) hc[i] = -100;
  endtask

  task automatic step(input bit v, input int a, input bit f,
                      input bit l, input bit ordy);
    logic [W-1:0] ep, res;
    bit er, eov;
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    hc[cyc % 4] = -100;
    if (sched.exists(cyc)) begin
      mt_result = sched[cyc];
      sched.delete(cyc);
    end else begin
      mt_result = rnd();
    end
    in_valid  = v;
    in_addr   = AW'(a);
    in_first  = f;
    in_last   = l;
    out_ready = ordy;
    #1;
    er = 1'b1;
    if (v && !f)
      for (int d = 1; d <= 2; d++) begin
        idx = (cyc - d) % 4;
        if (hc[idx] == cyc - d && ha[idx] == AW'(a)) er = 1'b0;
      end
    if (v && l && exp_q.size() >= FD) er = 1'b0;
    chk("in_ready", W'(in_ready), W'(er));
    eov = (exp_q.size() > 0) && (exp_q[0].c <= cyc - 4);
    chk("out_valid", W'(out_valid), W'(eov));
    if (v && in_ready) begin
      ep = '0;
      if (!f) ep = acc[a];
      chk("psum_out", psum_out, ep);
      res = vadd(ep, rnd());
      sched[cyc + 3] = res;
      if (l) exp_q.push_back('{a: AW'(a), d: res, c: cyc});
      else   acc[a] = res;
      hc[cyc % 4] = cyc;
      ha[cyc % 4] = AW'(a);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_first  = 1'b0;
    in_last   = 1'b1;
    in_addr   = AW'($urandom_range(0, DEPTH - 1));
    out_ready = 1'b0;
    mt_result = rnd();
    #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready", W'(in_ready), W'(1'b1));
    chk("rst_psum_out", psum_out, '0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    chk("post_rst_out_valid", W'(out_valid), '0);
    for (int s = 0; s < DEPTH; s++) begin
      in_addr = AW'(s);
      #1;
      chk("post_rst_buf", psum_out, '0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected cyc=%0d got_addr=%0d want=none",
                 cyc, out_addr);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("out_addr", W'(out_addr), W'(e.a));
        chk("out_data", out_data, e.d);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    clear_model();
    do_reset();

    step(1, 0, 1, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    repeat (6) step(0, 0, 0, 0, 1);

    step(1, 1, 1, 0, 1);
    repeat (3) step(1, 1, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 1);

    for (int i = 0; i < 40; i++)
      step(1, i % 4, i < 4, 0, 1);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1));

    for (int i = 0; i < 60; i++)
      step(1, $urandom_range(0, DEPTH - 1), $urandom_range(0, 2) == 0,
           $urandom_range(0, 1), 0);
    for (int i = 0; i < 80; i++)
      step(1, $urandom_range(0, DEPTH - 1), $urandom_range(0, 2) == 0,
           $urandom_range(0, 1), $urandom_range(0, 3) != 0);

    step(1, 0, 1, 1, 0);
    step(1, 1, 1, 0, 0);
    step(1, 2, 1, 1, 0);
    do_reset();
    repeat (5) step(0, 0, 0, 0, 1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) != 0);

    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      step(0, 0, 0, 0, 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got_pending=%0d want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
